fifo_uart_drain: RTL and testbench



---
 rtl/fifo_uart_drain.sv | 152 +++++++++++++++
 tb/tb_fifo_uart_drain.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_drain.sv
// ============================================================================
// Module   : fifo_uart_drain
// Purpose  : Pops nibble pairs from a CDC FIFO read port and sends each byte
//            (low nibble first) as an 8N1 UART frame; counts finished frames.
// Options  : define UART_DRAIN_PARITY_EN to insert an even-parity bit (8E1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_uart_drain #(
    parameter int DATA_WIDTH    = 4,
    parameter int CLOCK_DIVIDER = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] read_data,
    output logic                  read_increment,
    output logic                  tx,
    output logic                  busy,
    output logic [7:0]            frames_sent
);

    localparam int                BAUD_W    = (CLOCK_DIVIDER > 1) ? $clog2(CLOCK_DIVIDER) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLOCK_DIVIDER - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH_HI = 3'd1,
        S_START    = 3'd2,
        S_DATA     = 3'd3,
`ifdef UART_DRAIN_PARITY_EN
        S_PARITY   = 3'd5,
`endif
        S_STOP     = 3'd4
    } state_t;

    state_t              state_q;
    logic [7:0]          shift_q;
    logic [BAUD_W-1:0]   baud_q;
    logic [2:0]          bit_q;
    logic                tx_q;
    logic [7:0]          frames_q;
`ifdef UART_DRAIN_PARITY_EN
    logic                parity_q;
`endif

    logic w_baud_tc;
    logic w_fetching;

    assign w_baud_tc  = (baud_q == BAUD_LAST);
    assign w_fetching = (state_q == S_IDLE) || (state_q == S_FETCH_HI);

    // The FIFO head is combinational, so a pop and its capture share one edge.
    assign read_increment = w_fetching && !empty;
    assign busy           = (state_q != S_IDLE);
    assign tx             = tx_q;
    assign frames_sent    = frames_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            shift_q  <= 8'h00;
            baud_q   <= '0;
            bit_q    <= 3'd0;
            tx_q     <= 1'b1;
            frames_q <= 8'h00;
`ifdef UART_DRAIN_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!empty) begin
                        shift_q[3:0] <= read_data[3:0];
                        state_q      <= S_FETCH_HI;
                    end
                end
                S_FETCH_HI: begin
                    if (!empty) begin
                        shift_q[7:4] <= read_data[3:0];
`ifdef UART_DRAIN_PARITY_EN
                        parity_q     <= ^{read_data[3:0], shift_q[3:0]};
`endif
                        tx_q         <= 1'b0;
                        baud_q       <= '0;
                        state_q      <= S_START;
                    end
                end
                S_START: begin
                    if (w_baud_tc) begin
                        tx_q    <= shift_q[0];
                        shift_q <= {1'b0, shift_q[7:1]};
                        bit_q   <= 3'd0;
                        baud_q  <= '0;
                        state_q <= S_DATA;
                    end else begin
                        baud_q  <= baud_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_baud_tc) begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
`ifdef UART_DRAIN_PARITY_EN
                            tx_q    <= parity_q;
                            state_q <= S_PARITY;
`else
                            tx_q    <= 1'b1;
                            state_q <= S_STOP;
`endif
                        end else begin
                            tx_q    <= shift_q[0];
                            shift_q <= {1'b0, shift_q[7:1]};
                            bit_q   <= bit_q + 3'd1;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
`ifdef UART_DRAIN_PARITY_EN
                S_PARITY: begin
                    if (w_baud_tc) begin
                        tx_q    <= 1'b1;
                        baud_q  <= '0;
                        state_q <= S_STOP;
                    end else begin
                        baud_q  <= baud_q + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (w_baud_tc) begin
                        frames_q <= frames_q + 8'd1;
                        baud_q   <= '0;
                        state_q  <= S_IDLE;
                    end else begin
                        baud_q   <= baud_q + 1'b1;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    baud_q  <= '0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fifo_uart_drain.sv
// ============================================================================
// Module   : tb_fifo_uart_drain
// Purpose  : Directed, table-driven bench for fifo_uart_drain with a queue
//            standing in for the FIFO read port. Honors UART_DRAIN_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_uart_drain;

    localparam int CD = 4;
`ifdef UART_DRAIN_PARITY_EN
    localparam int NSYM = 11;
`else
    localparam int NSYM = 10;
`endif

    logic       clock     = 1'b0;
    logic       reset     = 1'b1;
    logic       empty     = 1'b1;
    logic [3:0] read_data = 4'h0;
    wire        read_increment;
    wire        tx;
    wire        busy;
    wire [7:0]  frames_sent;

    always #5 clock = ~clock;

    fifo_uart_drain #(
        .DATA_WIDTH    (4),
        .CLOCK_DIVIDER (CD)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .empty          (empty),
        .read_data      (read_data),
        .read_increment (read_increment),
        .tx             (tx),
        .busy           (busy),
        .frames_sent    (frames_sent)
    );

    // frame[k] is the k-th transmitted symbol: start, 8 data LSB first, stop
    typedef struct {
        logic [3:0] lo;
        logic [3:0] hi;
        logic [9:0] frame;
        logic       par;
    } vec_t;

    vec_t       vecs[6];
    logic [3:0] fifo_q[$];
    int         pops;
    int         checks;
    int         failures;
    int         exp_frames;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic refresh();
        empty     = (fifo_q.size() == 0);
        read_data = empty ? 4'h0 : fifo_q[0];
    endtask

    task automatic push(input logic [3:0] n);
        fifo_q.push_back(n);
        refresh();
    endtask

    // One clock: note the pop request seen at the edge, then update the FIFO model.
    task automatic step();
        logic pop;
        @(posedge clock);
        pop = read_increment;
        #1;
        if (pop) begin
            checks++;
            if (fifo_q.size() == 0) begin
                failures++;
                $display("FAIL pop_underflow actual=pop_on_empty expected=no_pop");
            end else begin
                void'(fifo_q.pop_front());
                pops++;
            end
        end
        refresh();
    endtask

    task automatic wait_start(input string name);
        for (int i = 0; i < 200; i++) begin
            if (tx === 1'b0) return;
            step();
        end
        checks++;
        failures++;
        $display("FAIL %s_timeout actual=no_start_bit expected=start_within_200", name);
    endtask

    function automatic logic sym(input logic [9:0] f, input logic p, input int k);
        int s;
        s = k / CD;
`ifdef UART_DRAIN_PARITY_EN
        if (s == 9)  return p;
        if (s == 10) return 1'b1;
`endif
        return f[s];
    endfunction

    // Entered on the first start-bit cycle; leaves on the first cycle after the stop bit.
    task automatic check_frame(input string name, input logic [9:0] f, input logic p);
        int bad;
        int first_bad;
        bad       = 0;
        first_bad = -1;
        for (int k = 0; k < NSYM * CD; k++) begin
            if (k > 0) step();
            if (tx !== sym(f, p, k) || busy !== 1'b1) begin
                bad++;
                if (first_bad < 0) first_bad = k;
            end
        end
        check({name, "_bad_cycles"}, bad, 0);
        if (bad != 0) $display("  first bad cycle in %s: %0d", name, first_bad);
        step();
        exp_frames++;
        check({name, "_frames_sent"}, {24'h0, frames_sent}, exp_frames & 8'hFF);
        check({name, "_busy_after"}, {31'h0, busy}, 0);
    endtask

    initial begin
        int bad;
        int gap;
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bad;
        int gap;
        checks     = 0;
        failures   = 0;
        pops       = 0;
        exp_frames = 0;

        vecs[0] = '{lo: 4'h5, hi: 4'hA, frame: 10'h34A, par: 1'b0};
        vecs[1] = '{lo: 4'h7, hi: 4'h0, frame: 10'h20E, par: 1'b1};
        vecs[2] = '{lo: 4'h0, hi: 4'h0, frame: 10'h200, par: 1'b0};
        vecs[3] = '{lo: 4'hF, hi: 4'hF, frame: 10'h3FE, par: 1'b0};
        vecs[4] = '{lo: 4'h1, hi: 4'h8, frame: 10'h302, par: 1'b0};
        vecs[5] = '{lo: 4'h1, hi: 4'h0, frame: 10'h202, par: 1'b1};

        // Reset with the FIFO empty
        repeat (3) @(posedge clock);
        #1;
        check("rst_tx",     {31'h0, tx},             1);
        check("rst_busy",   {31'h0, busy},           0);
        check("rst_ri",     {31'h0, read_increment}, 0);
        check("rst_frames", {24'h0, frames_sent},    0);
        reset = 1'b0;
        repeat (5) step();
        check("idle_tx",     {31'h0, tx},             1);
        check("idle_busy",   {31'h0, busy},           0);
        check("idle_ri",     {31'h0, read_increment}, 0);
        check("idle_frames", {24'h0, frames_sent},    0);

        // Table of single frames
        for (int i = 0; i < 6; i++) begin
            pops = 0;
            push(vecs[i].lo);
            push(vecs[i].hi);
            wait_start($sformatf("vec%0d", i));
            check_frame($sformatf("vec%0d", i), vecs[i].frame, vecs[i].par);
            check($sformatf("vec%0d_pops", i), pops, 2);
        end

        // Starved high nibble: low nibble held, line idle, busy high
        pops = 0;
        push(4'h3);
        step();
        bad = 0;
        repeat (50) begin
            step();
            if (tx !== 1'b1 || busy !== 1'b1 || read_increment !== 1'b0) bad++;
        end
        check("starve_wait_bad", bad, 0);
        push(4'hC);
        step();
        check("starve_start_next_cycle", {31'h0, tx}, 0);
        check_frame("starve", 10'h386, 1'b0);
        check("starve_pops", pops, 2);

        // Back-to-back frames from a preloaded FIFO
        pops = 0;
        for (int i = 0; i < 4; i++) begin
            fifo_q.push_back(vecs[i].lo);
            fifo_q.push_back(vecs[i].hi);
        end
        refresh();
        wait_start("b2b");
        for (int i = 0; i < 4; i++) begin
            check_frame($sformatf("b2b%0d", i), vecs[i].frame, vecs[i].par);
            if (i < 3) begin
                gap = 0;
                while (tx === 1'b1 && gap < 50) begin
                    gap++;
                    step();
                end
                check($sformatf("b2b%0d_gap", i), gap, 2);
            end
        end
        check("b2b_pops", pops, 8);

        // Reset during DATA bit 3 of 0xA5
        pops = 0;
        push(4'h5);
        push(4'hA);
        wait_start("mid");
        repeat (17) step();
        check("mid_pre_reset_tx", {31'h0, tx}, 0);
        reset = 1'b1;
        #1;
        check("mid_rst_tx",     {31'h0, tx},          1);
        check("mid_rst_frames", {24'h0, frames_sent}, 0);
        check("mid_rst_busy",   {31'h0, busy},        0);
        exp_frames = 0;
        #1;
        reset = 1'b0;
        pops  = 0;
        push(4'h7);
        push(4'h0);
        wait_start("post");
        check_frame("post", 10'h20E, 1'b1);
        check("post_pops", pops, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
